// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the imem req/ack port
// and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_src,
    input  logic [31:0] target,
    input  logic        if_flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] kill_addr;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc4;
    logic        redirect;
    logic [31:0] redir_pc;
    logic [31:0] pc4;

    // Redirect decode; target is forced word aligned.
    always_comb begin
        redirect = (pc_src == 2'b01) || (pc_src == 2'b10);
        redir_pc = (pc_src == 2'b01) ? {target[31:2], 2'b00}
                                     : EXC_VECTOR;
        pc4      = pc + 32'd4;
    end

    // A killed fetch keeps presenting its own address until acked.
    assign imem_req  = rst_n && (state != HOLD);
    assign imem_addr = (state == KILL) ? kill_addr : pc;

    // Fetch FSM, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            kill_addr   <= RESET_PC;
            hold_inst   <= '0;
            hold_pc4    <= '0;
            if_id_inst  <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc          <= redir_pc;
                            if_id_inst  <= '0;
                            if_id_valid <= 1'b0;
                        end else if (if_flush) begin
                            if_id_inst  <= '0;
                            if_id_valid <= 1'b0;
                        end else if (stall) begin
                            hold_inst <= imem_rdata;
                            hold_pc4  <= pc4;
                            pc        <= pc4;
                            state     <= HOLD;
                        end else begin
                            if_id_inst  <= imem_rdata;
                            if_id_pc4   <= pc4;
                            if_id_valid <= 1'b1;
                            pc          <= pc4;
                        end
                    end else begin
                        if (redirect) begin
                            kill_addr   <= pc;
                            pc          <= redir_pc;
                            if_id_inst  <= '0;
                            if_id_valid <= 1'b0;
                            state       <= KILL;
                        end else if (if_flush || !stall) begin
                            if_id_inst  <= '0;
                            if_id_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc          <= redir_pc;
                        if_id_inst  <= '0;
                        if_id_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (if_flush) begin
                        pc          <= hold_pc4 - 32'd4;
                        if_id_inst  <= '0;
                        if_id_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (!stall) begin
                        if_id_inst  <= hold_inst;
                        if_id_pc4   <= hold_pc4;
                        if_id_valid <= 1'b1;
                        state       <= FETCH;
                    end
                end
                KILL: begin
                    if_id_inst  <= '0;
                    if_id_valid <= 1'b0;
                    if (redirect) begin
                        pc <= redir_pc;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table plus
// randomized run against a queue-based reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] target;
    logic        if_flush;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int tests = 0;
    int fails = 0;

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_src     (pc_src),
        .target     (target),
        .if_flush   (if_flush),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .if_id_inst (if_id_inst),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hAB00_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [31:0] tgt;
        logic        fl;
        logic        st;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        vld;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] src, input logic [31:0] tgt,
        input logic fl, input logic st, input logic ack,
        input logic req, input logic [31:0] addr,
        input logic [31:0] inst, input logic [31:0] pc4,
        input logic vld);
        vec_t v;
        v.src = src; v.tgt = tgt; v.fl = fl; v.st = st;
        v.ack = ack; v.req = req; v.addr = addr;
        v.inst = inst; v.pc4 = pc4; v.vld = vld;
        return v;
    endfunction

    // Reference model: architectural next PC, a queue holding a
    // stalled-but-fetched instruction, and a queue of killed
    // requests still owed an ack.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } held_t;

    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_vld;
    held_t       hq[$];
    logic [31:0] kq[$];

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
        hq.delete();
        kq.delete();
    endtask

    task automatic model_step(input logic [1:0] src,
                              input logic [31:0] tgt,
                              input logic fl, input logic st,
                              input logic ack,
                              input logic [31:0] rd);
        logic        redir;
        logic [31:0] dest;
        held_t       h;
        redir = (src == 2'd1) || (src == 2'd2);
        dest  = (src == 2'd1) ? (tgt & 32'hFFFF_FFFC) : 32'h180;
        if (kq.size() != 0) begin
            m_inst = 0; m_vld = 0;
            if (redir) m_pc = dest;
            if (ack) void'(kq.pop_front());
        end else if (hq.size() != 0) begin
            if (redir) begin
                hq.delete(); m_pc = dest; m_inst = 0; m_vld = 0;
            end else if (fl) begin
                m_pc = hq[0].pc4 - 32'd4;
                hq.delete(); m_inst = 0; m_vld = 0;
            end else if (!st) begin
                m_inst = hq[0].inst; m_pc4 = hq[0].pc4; m_vld = 1;
                hq.delete();
            end
        end else if (ack) begin
            if (redir) begin
                m_pc = dest; m_inst = 0; m_vld = 0;
            end else if (fl) begin
                m_inst = 0; m_vld = 0;
            end else if (st) begin
                h.inst = rd; h.pc4 = m_pc + 32'd4;
                hq.push_back(h);
                m_pc = m_pc + 32'd4;
            end else begin
                m_inst = rd; m_pc4 = m_pc + 32'd4; m_vld = 1;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (redir) begin
                kq.push_back(m_pc); m_pc = dest; m_inst = 0; m_vld = 0;
            end else if (fl || !st) begin
                m_inst = 0; m_vld = 0;
            end
        end
    endtask

    vec_t vt[27];

    initial begin
        logic        busy;
        int          wl;
        logic [31:0] baddr;
        logic [1:0]  s;
        logic [31:0] t;
        logic        f, st, a;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        int          r;

        vt[0]  = mk(0, 0, 0, 0, 1, 1, 32'h4,   tag(32'h0),   32'h4,   1);
        vt[1]  = mk(0, 0, 0, 0, 1, 1, 32'h8,   tag(32'h4),   32'h8,   1);
        vt[2]  = mk(1, 32'h40, 0, 0, 1, 1, 32'h40, 0,        32'h8,   0);
        vt[3]  = mk(0, 0, 0, 0, 1, 1, 32'h44,  tag(32'h40),  32'h44,  1);
        vt[4]  = mk(0, 0, 0, 0, 0, 1, 32'h44,  0,            32'h44,  0);
        vt[5]  = mk(1, 32'h100, 0, 0, 0, 1, 32'h44, 0,       32'h44,  0);
        vt[6]  = mk(0, 0, 0, 0, 0, 1, 32'h44,  0,            32'h44,  0);
        vt[7]  = mk(0, 0, 0, 0, 1, 1, 32'h100, 0,            32'h44,  0);
        vt[8]  = mk(0, 0, 0, 0, 1, 1, 32'h104, tag(32'h100), 32'h104, 1);
        vt[9]  = mk(0, 0, 0, 1, 1, 0, 32'h0,   tag(32'h100), 32'h104, 1);
        vt[10] = mk(0, 0, 0, 1, 0, 0, 32'h0,   tag(32'h100), 32'h104, 1);
        vt[11] = mk(0, 0, 0, 1, 0, 0, 32'h0,   tag(32'h100), 32'h104, 1);
        vt[12] = mk(0, 0, 0, 0, 0, 1, 32'h108, tag(32'h104), 32'h108, 1);
        vt[13] = mk(0, 0, 0, 0, 1, 1, 32'h10C, tag(32'h108), 32'h10C, 1);
        vt[14] = mk(0, 0, 1, 0, 1, 1, 32'h10C, 0,            32'h10C, 0);
        vt[15] = mk(0, 0, 0, 0, 1, 1, 32'h110, tag(32'h10C), 32'h110, 1);
        vt[16] = mk(0, 0, 0, 1, 1, 0, 32'h0,   tag(32'h10C), 32'h110, 1);
        vt[17] = mk(2, 0, 0, 0, 0, 1, 32'h180, 0,            32'h110, 0);
        vt[18] = mk(0, 0, 0, 0, 1, 1, 32'h184, tag(32'h180), 32'h184, 1);
        vt[19] = mk(0, 0, 0, 1, 1, 0, 32'h0,   tag(32'h180), 32'h184, 1);
        vt[20] = mk(0, 0, 1, 0, 0, 1, 32'h184, 0,            32'h184, 0);
        vt[21] = mk(0, 0, 0, 0, 1, 1, 32'h188, tag(32'h184), 32'h188, 1);
        vt[22] = mk(1, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'hFFFF_FFFC, 0,
                    32'h188, 0);
        vt[23] = mk(0, 0, 0, 0, 1, 1, 32'h0, tag(32'hFFFF_FFFC),
                    32'h0, 1);
        vt[24] = mk(0, 0, 0, 1, 0, 1, 32'h0, tag(32'hFFFF_FFFC),
                    32'h0, 1);
        vt[25] = mk(0, 0, 1, 0, 0, 1, 32'h0,   0,            32'h0,   0);
        vt[26] = mk(3, 32'h500, 0, 0, 1, 1, 32'h4, tag(32'h0), 32'h4, 1);

        rst_n = 1'b0; pc_src = 0; target = 0; if_flush = 0;
        stall = 0; imem_ack = 0; imem_rdata = 0;
        #1;
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            pc_src     = vt[i].src;
            target     = vt[i].tgt;
            if_flush   = vt[i].fl;
            stall      = vt[i].st;
            imem_ack   = vt[i].ack;
            imem_rdata = vt[i].ack ? tag(imem_addr) : 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, imem_req},
                {31'h0, vt[i].req});
            if (vt[i].req)
                chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("v%0d_inst", i), if_id_inst, vt[i].inst);
            chk($sformatf("v%0d_pc4", i), if_id_pc4, vt[i].pc4);
            chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid},
                {31'h0, vt[i].vld});
        end

        // Reset asserted while a fetch is outstanding.
        @(negedge clk);
        pc_src = 0; if_flush = 0; stall = 0; imem_ack = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_valid", {31'h0, if_id_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_addr", imem_addr, 32'h0);

        model_reset();
        busy = 1'b0; wl = 0; baddr = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            s = (r < 10) ? 2'd1 : (r < 13) ? 2'd2 : (r < 16) ? 2'd3 : 2'd0;
            t = $urandom_range(0, 32'h3FF);
            f = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 99) < 20) && !(s == 2'd1 || s == 2'd2);
            a = 1'b0;
            rd = $urandom;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wl = $urandom_range(0, 3);
                    baddr = imem_addr;
                end else begin
                    chk("rnd_addr_stable", imem_addr, baddr);
                end
                if (wl == 0) begin
                    a = 1'b1;
                    rd = tag(imem_addr);
                end else begin
                    wl--;
                end
            end
            pc_src = s; target = t; if_flush = f; stall = st;
            imem_ack = a; imem_rdata = rd;
            @(posedge clk);
            model_step(s, t, f, st, a, rd);
            if (a) busy = 1'b0;
            #1;
            e_req  = (hq.size() == 0);
            e_addr = (kq.size() != 0) ? kq[0] : m_pc;
            chk("rnd_req", {31'h0, imem_req}, {31'h0, e_req});
            if (e_req) chk("rnd_addr", imem_addr, e_addr);
            chk("rnd_inst", if_id_inst, m_inst);
            chk("rnd_pc4", if_id_pc4, m_pc4);
            chk("rnd_valid", {31'h0, if_id_valid}, {31'h0, m_vld});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
